multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main controller: Moore FSM driving datapath selects, with
// handshake-dependent PC/IR enables. Define MIPS_JUMP_EN to enable the J path.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BEQEX  = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10
`ifdef MIPS_JUMP_EN
    , JEX  = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic       rtype_ok;
  logic [2:0] rtype_alu;

  // NOTE: reset is synchronous, so it lives inside the clocked block; state
  // uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Supported R-type functions and their ALU operation.
  always_comb begin
    rtype_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    case (funct)
      FN_ADD:  rtype_alu = ALU_ADD;
      FN_SUB:  rtype_alu = ALU_SUB;
      FN_AND:  rtype_alu = ALU_AND;
      FN_OR:   rtype_alu = ALU_OR;
      FN_SLT:  rtype_alu = ALU_SLT;
      default: rtype_ok  = 1'b0;
    endcase
  end

  // NOTE: every output and state_d gets a default before the case so that no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    pcen       = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
`ifdef MIPS_JUMP_EN
          OP_J:         state_d = JEX;
`endif
          OP_RTYPE: begin
            if (rtype_ok) begin
              state_d = RTEX;
            end else begin
              illegal = 1'b1;
              state_d = FETCH;
            end
          end
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWR;
      end
      RTEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        state_d    = RTWB;
      end
      RTWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
        state_d    = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
`ifdef MIPS_JUMP_EN
      JEX: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase

    // Strobes must not fire while reset is held, whatever the state.
    if (reset) begin
      memwrite = 1'b0;
      regwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed and random instruction streams compared
// cycle by cycle against an instruction-level path/output reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, illegal;
  logic [3:0] state;

  int total = 0;
  int bad = 0;

`ifdef MIPS_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] dut_outs;
  assign dut_outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, pcsrc, alucontrol, pcen, illegal};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000) return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    if (o == 6'b000010) return JUMP_EN;
    return o inside {6'b100011, 6'b101011, 6'b000100, 6'b001000};
  endfunction

  // Expected output bundle for a state code, in the same order as dut_outs.
  function automatic logic [15:0] exp_out(input int s, input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input logic mr, input logic rst);
    logic e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_pcen, e_ill;
    logic [1:0] e_b, e_pcsrc;
    logic [2:0] e_alu;
    {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_pcen, e_ill} = '0;
    e_b = 2'b00; e_pcsrc = 2'b00; e_alu = 3'b010;
    case (s)
      0:  begin e_b = 2'b01; e_irw = mr; e_pcen = mr; end
      1:  begin e_b = 2'b11; e_ill = !legal(o, f); end
      2:  begin e_a = 1'b1; e_b = 2'b10; end
      3:  e_iord = 1'b1;
      4:  begin e_m2r = 1'b1; e_rw = 1'b1; end
      5:  begin e_iord = 1'b1; e_mw = 1'b1; end
      6:  begin
            e_a = 1'b1;
            case (f)
              6'b100010: e_alu = 3'b110;
              6'b100100: e_alu = 3'b000;
              6'b100101: e_alu = 3'b001;
              6'b101010: e_alu = 3'b111;
              default:   e_alu = 3'b010;
            endcase
          end
      7:  begin e_rd = 1'b1; e_rw = 1'b1; end
      8:  begin e_a = 1'b1; e_alu = 3'b110; e_pcsrc = 2'b01; e_pcen = z; end
      9:  begin e_a = 1'b1; e_b = 2'b10; end
      10: e_rw = 1'b1;
      11: begin e_pcsrc = 2'b10; e_pcen = 1'b1; end
      default: ;
    endcase
    if (rst) {e_mw, e_rw, e_irw, e_pcen, e_ill} = '0;
    return {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_b, e_pcsrc, e_alu, e_pcen, e_ill};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check mid-cycle.
  task automatic step(input int s, input logic mr, input logic rst, input logic [5:0] o,
                      input logic [5:0] f, input logic z, input string tag);
    @(negedge clk);
    reset = rst; op = o; funct = f; zero = z; mem_ready = mr;
    #1;
    check({tag, "/state"}, {12'd0, state}, 16'(s));
    check({tag, "/outs"}, dut_outs, exp_out(s, o, f, z, mr, rst));
  endtask

  // Whole instruction: state path from the instruction class, plus wait cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fwait, input int mwait, input string tag);
    int path[$];
    if (!legal(o, f))            path = '{0, 1};
    else if (o == 6'b100011)     path = '{0, 1, 2, 3, 4};
    else if (o == 6'b101011)     path = '{0, 1, 2, 5};
    else if (o == 6'b000000)     path = '{0, 1, 6, 7};
    else if (o == 6'b000100)     path = '{0, 1, 8};
    else if (o == 6'b001000)     path = '{0, 1, 9, 10};
    else                         path = '{0, 1, 11};
    foreach (path[k]) begin
      int n;
      n = (path[k] == 0) ? fwait : (path[k] inside {3, 5}) ? mwait : 0;
      for (int c = 0; c <= n; c++) begin
        logic mr;
        if (path[k] inside {0, 3, 5}) mr = (c == n);
        else mr = 1'($urandom_range(0, 1));
        step(path[k], mr, 1'b0, o, f, z, tag);
      end
    end
  endtask

  initial begin
    logic [5:0] legal_fn [5];
    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Reset held with mem_ready high: FETCH but no enables.
    step(0, 1'b1, 1'b1, 6'b100011, 6'd0, 1'b0, "reset0");
    step(0, 1'b1, 1'b1, 6'b100011, 6'd0, 1'b0, "reset1");

    run_instr(6'b100011, 6'd0, 1'b0, 0, 0, "lw");
    run_instr(6'b101011, 6'd0, 1'b0, 0, 3, "sw_wait3");
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0, "beq_taken");
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0, "beq_not");
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, "slt");
    run_instr(6'b000000, 6'b100010, 1'b0, 2, 0, "sub_fwait");
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0, "addi");
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, "illegal_op");
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0, "jump");
    run_instr(6'b000000, 6'b000111, 1'b0, 0, 0, "illegal_fn");
    run_instr(6'b100011, 6'd0, 1'b0, 1, 2, "lw_waits");

    // Reset during a MEMRD wait.
    step(0, 1'b1, 1'b0, 6'b100011, 6'd0, 1'b0, "rst_rd");
    step(1, 1'b1, 1'b0, 6'b100011, 6'd0, 1'b0, "rst_rd");
    step(2, 1'b1, 1'b0, 6'b100011, 6'd0, 1'b0, "rst_rd");
    step(3, 1'b0, 1'b0, 6'b100011, 6'd0, 1'b0, "rst_rd");
    step(3, 1'b0, 1'b1, 6'b100011, 6'd0, 1'b0, "rst_rd_assert");
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0, "after_rst_rd");

    // Reset during a MEMWR wait: memwrite must drop while reset is high.
    step(0, 1'b1, 1'b0, 6'b101011, 6'd0, 1'b0, "rst_wr");
    step(1, 1'b1, 1'b0, 6'b101011, 6'd0, 1'b0, "rst_wr");
    step(2, 1'b1, 1'b0, 6'b101011, 6'd0, 1'b0, "rst_wr");
    step(5, 1'b0, 1'b0, 6'b101011, 6'd0, 1'b0, "rst_wr");
    step(5, 1'b0, 1'b1, 6'b101011, 6'd0, 1'b0, "rst_wr_assert");
    run_instr(6'b000000, 6'b100101, 1'b0, 0, 0, "after_rst_wr");

    // Random instruction stream.
    for (int i = 0; i < 80; i++) begin
      logic [5:0] o, f;
      logic z;
      int kind;
      kind = int'($urandom_range(0, 7));
      z = 1'($urandom_range(0, 1));
      f = 6'($urandom);
      case (kind)
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: begin o = 6'b000000; f = legal_fn[$urandom_range(0, 4)]; end
        3: o = 6'b000100;
        4: o = 6'b001000;
        5: o = 6'b000010;
        6: begin
             o = 6'($urandom);
             if (legal(o, f) || o == 6'b000000) o = 6'b111111;
           end
        default: begin
             o = 6'b000000;
             if (legal(o, f)) f = 6'b000001;
           end
      endcase
      run_instr(o, f, z, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
